// File: rtl/tile_pkg.sv
// Shared constants, state encoding and board helpers for the tile match game.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tile_pkg;

  localparam int NUM_TILES = 16;
  localparam int TILE_W    = 3;
  localparam int NUM_PAIRS = 8;
  localparam int BOARD_W   = NUM_TILES * TILE_W;
  localparam int IDX_W     = 4;
  localparam int PAIR_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_SECOND  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WON     = 3'd5
  } state_e;

  // Extract the value of tile idx from a packed board.
  function automatic logic [TILE_W-1:0] tile_at(input logic [BOARD_W-1:0] board,
                                                input logic [IDX_W-1:0]   idx);
    int base;
    base   = int'(idx) * TILE_W;
    tile_at = board[base +: TILE_W];
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Load/count-down timer that measures how long a mismatched pair stays visible.
// Latency: done pulses HOLD_CYCLES cycles after start (start cycle excluded).
// Backpressure: none; clear wins over start, start reloads a running count.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic done_o
);

  // HOLD_CYCLES is expected to be at least 1; the width floor keeps a legal vector.
  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, reload on start, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = CNT_W'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last cycle of the window: exactly one cycle per start.
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tile_match_engine.sv
// Memory-match game engine: latches a board, takes tile picks, compares pairs, tracks score.
// Latency: pick registered at the accepting edge; compare results one cycle later.
// Backpressure: sel_ready low outside FIRST/SECOND; unready or invalid picks are dropped.
module tile_match_engine
  import tile_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MOVE_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BOARD_W-1:0]   shuffled_vals,
  input  logic                 load,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  output logic [NUM_TILES-1:0] face_up,
  output logic [NUM_TILES-1:0] matched,
  output logic [BOARD_W-1:0]   tile_vals,
  output logic [MOVE_W-1:0]    moves,
  output logic [PAIR_W-1:0]    pairs_found,
  output logic                 match_pulse,
  output logic                 miss_pulse,
  output logic                 sel_ready,
  output logic                 game_won
);

  state_e               state_q,       state_d;
  logic [BOARD_W-1:0]   tile_vals_q,   tile_vals_d;
  logic [NUM_TILES-1:0] face_up_q,     face_up_d;
  logic [NUM_TILES-1:0] matched_q,     matched_d;
  logic [MOVE_W-1:0]    moves_q,       moves_d;
  logic [PAIR_W-1:0]    pairs_q,       pairs_d;
  logic                 match_pulse_q, match_pulse_d;
  logic                 miss_pulse_q,  miss_pulse_d;
  logic [IDX_W-1:0]     idx_a_q,       idx_a_d;
  logic [IDX_W-1:0]     idx_b_q,       idx_b_d;

  logic timer_start;
  logic timer_clear;
  logic timer_done;
  logic sel_rdy;
  logic sel_ok;
  logic vals_equal;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (timer_start),
    .clear_i (timer_clear),
    .done_o  (timer_done)
  );

  assign sel_rdy    = (state_q == ST_FIRST) || (state_q == ST_SECOND);
  // A pick only counts when ready and the tile is not already showing.
  assign sel_ok     = sel_valid && sel_rdy && !face_up_q[sel_idx];
  assign vals_equal = (tile_at(tile_vals_q, idx_a_q) == tile_at(tile_vals_q, idx_b_q));

  // Next-state and datapath updates; load overrides everything, including a same-cycle pick.
  always_comb begin
    state_d       = state_q;
    tile_vals_d   = tile_vals_q;
    face_up_d     = face_up_q;
    matched_d     = matched_q;
    moves_d       = moves_q;
    pairs_d       = pairs_q;
    idx_a_d       = idx_a_q;
    idx_b_d       = idx_b_q;
    match_pulse_d = 1'b0;
    miss_pulse_d  = 1'b0;
    timer_start   = 1'b0;
    timer_clear   = 1'b0;

    if (load) begin
      tile_vals_d = shuffled_vals;
      face_up_d   = '0;
      matched_d   = '0;
      moves_d     = '0;
      pairs_d     = '0;
      idx_a_d     = '0;
      idx_b_d     = '0;
      timer_clear = 1'b1;
      state_d     = ST_FIRST;
    end else begin
      case (state_q)
        ST_FIRST: begin
          if (sel_ok) begin
            face_up_d[sel_idx] = 1'b1;
            idx_a_d            = sel_idx;
            state_d            = ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (sel_ok && (sel_idx != idx_a_q)) begin
            face_up_d[sel_idx] = 1'b1;
            idx_b_d            = sel_idx;
            state_d            = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (moves_q != '1) begin
            moves_d = moves_q + 1'b1;
          end
          if (vals_equal) begin
            matched_d[idx_a_q] = 1'b1;
            matched_d[idx_b_q] = 1'b1;
            pairs_d            = pairs_q + 1'b1;
            match_pulse_d      = 1'b1;
            state_d            = (pairs_q == PAIR_W'(NUM_PAIRS - 1)) ? ST_WON : ST_FIRST;
          end else begin
            miss_pulse_d = 1'b1;
            timer_start  = 1'b1;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (timer_done) begin
            face_up_d[idx_a_q] = 1'b0;
            face_up_d[idx_b_q] = 1'b0;
            state_d            = ST_FIRST;
          end
        end
        default: begin
          // IDLE and WON only leave on load.
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers; reset clears every output-visible bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      tile_vals_q   <= '0;
      face_up_q     <= '0;
      matched_q     <= '0;
      moves_q       <= '0;
      pairs_q       <= '0;
      idx_a_q       <= '0;
      idx_b_q       <= '0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tile_vals_q   <= tile_vals_d;
      face_up_q     <= face_up_d;
      matched_q     <= matched_d;
      moves_q       <= moves_d;
      pairs_q       <= pairs_d;
      idx_a_q       <= idx_a_d;
      idx_b_q       <= idx_b_d;
      match_pulse_q <= match_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
    end
  end

  // Matched tiles always show, even if a face_up bit were ever cleared.
  assign face_up     = face_up_q | matched_q;
  assign matched     = matched_q;
  assign tile_vals   = tile_vals_q;
  assign moves       = moves_q;
  assign pairs_found = pairs_q;
  assign match_pulse = match_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign sel_ready   = sel_rdy;
  assign game_won    = (state_q == ST_WON);

endmodule

// File: tb/tb_tile_match_engine.sv
// Directed bench for tile_match_engine with hand-computed expectations.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: waits on sel_ready are bounded by a cycle budget.
module tb_tile_match_engine;

  localparam logic [47:0] BOARD = 48'o7654321076543210;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] shuffled_vals;
  logic        load;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [47:0] tile_vals;
  logic [7:0]  moves;
  logic [3:0]  pairs_found;
  logic        match_pulse;
  logic        miss_pulse;
  logic        sel_ready;
  logic        game_won;

  int tests = 0;
  int fails = 0;

  tile_match_engine #(
    .HOLD_CYCLES (4),
    .MOVE_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .shuffled_vals (shuffled_vals),
    .load          (load),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx),
    .face_up       (face_up),
    .matched       (matched),
    .tile_vals     (tile_vals),
    .moves         (moves),
    .pairs_found   (pairs_found),
    .match_pulse   (match_pulse),
    .miss_pulse    (miss_pulse),
    .sel_ready     (sel_ready),
    .game_won      (game_won)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input int idx);
    sel_valid = 1'b1;
    sel_idx   = 4'(idx);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!sel_ready && n < 20) begin
      tick();
      n++;
    end
    if (!sel_ready) check(tag, 64'(sel_ready), 64'd1);
  endtask

  initial begin
    reset         = 1'b0;
    shuffled_vals = BOARD;
    load          = 1'b0;
    sel_valid     = 1'b0;
    sel_idx       = 4'd0;
    tick();
    tick();
    check("rst_face_up",  64'(face_up),   64'h0);
    check("rst_tile_vals", 64'(tile_vals), 64'h0);
    check("rst_moves",    64'(moves),     64'h0);
    check("rst_ready",    64'(sel_ready), 64'h0);
    check("rst_won",      64'(game_won),  64'h0);
    reset = 1'b1;
    tick();

    // IDLE ignores picks
    pick(2);
    check("idle_ignore", 64'(face_up), 64'h0);

    // Match 0/8
    do_load();
    check("load_vals",  64'(tile_vals), 64'(BOARD));
    check("load_ready", 64'(sel_ready), 64'd1);
    pick(0);
    check("first_face", 64'(face_up), 64'h0001);
    pick(8);
    check("cmp_ready",  64'(sel_ready), 64'd0);
    check("cmp_nopulse", 64'(match_pulse), 64'd0);
    tick();
    check("match_pulse",   64'(match_pulse), 64'd1);
    check("match_matched", 64'(matched),     64'h0101);
    check("match_pairs",   64'(pairs_found), 64'd1);
    check("match_moves",   64'(moves),       64'd1);
    check("match_ready",   64'(sel_ready),   64'd1);
    tick();
    check("match_pulse_w", 64'(match_pulse), 64'd0);

    // Ignored picks: reselect A, then matched tiles
    pick(3);
    pick(3);
    check("resel_face",  64'(face_up),   64'h0109);
    check("resel_ready", 64'(sel_ready), 64'd1);
    check("resel_moves", 64'(moves),     64'd1);
    pick(11);
    tick();
    check("m2_matched", 64'(matched), 64'h0909);
    check("m2_moves",   64'(moves),   64'd2);
    pick(3);
    pick(11);
    check("matched_ign_face", 64'(face_up), 64'h0909);
    pick(4);
    pick(12);
    tick();
    check("m3_moves", 64'(moves),       64'd3);
    check("m3_pairs", 64'(pairs_found), 64'd3);

    // Mismatch 0/1 and HOLD window
    do_load();
    pick(0);
    pick(1);
    tick();
    check("miss_pulse",   64'(miss_pulse), 64'd1);
    check("miss_moves",   64'(moves),      64'd1);
    check("miss_face",    64'(face_up),    64'h0003);
    check("miss_nomatch", 64'(match_pulse), 64'd0);
    pick(5);
    check("hold_ign_face", 64'(face_up),    64'h0003);
    check("miss_pulse_w",  64'(miss_pulse), 64'd0);
    tick();
    check("hold3_face", 64'(face_up), 64'h0003);
    tick();
    check("hold4_face",  64'(face_up),   64'h0003);
    check("hold4_ready", 64'(sel_ready), 64'd0);
    tick();
    check("hold_end_face",  64'(face_up),   64'h0000);
    check("hold_end_ready", 64'(sel_ready), 64'd1);
    check("hold_end_moves", 64'(moves),     64'd1);

    // Win
    do_load();
    for (int i = 0; i < 8; i++) begin
      pick(i);
      pick(i + 8);
      tick();
    end
    check("win_pairs", 64'(pairs_found), 64'd8);
    check("win_won",   64'(game_won),    64'd1);
    check("win_face",  64'(face_up),     64'hFFFF);
    check("win_moves", 64'(moves),       64'd8);
    check("win_ready", 64'(sel_ready),   64'd0);
    pick(0);
    pick(8);
    tick();
    check("win_after_moves", 64'(moves),    64'd8);
    check("win_after_won",   64'(game_won), 64'd1);

    // Load during HOLD
    do_load();
    check("reload_won", 64'(game_won), 64'd0);
    pick(0);
    pick(1);
    tick();
    tick();
    do_load();
    check("abort_hold_face",  64'(face_up),   64'h0);
    check("abort_hold_moves", 64'(moves),     64'd0);
    check("abort_hold_ready", 64'(sel_ready), 64'd1);

    // Load during COMPARE
    pick(0);
    pick(8);
    do_load();
    check("abort_cmp_moves", 64'(moves),       64'd0);
    check("abort_cmp_pairs", 64'(pairs_found), 64'd0);
    check("abort_cmp_pulse", 64'(match_pulse), 64'd0);
    tick();
    check("abort_cmp_late", 64'(matched), 64'h0);

    // Load with coincident pick
    load      = 1'b1;
    sel_valid = 1'b1;
    sel_idx   = 4'd5;
    tick();
    load      = 1'b0;
    sel_valid = 1'b0;
    check("load_sel_face", 64'(face_up), 64'h0);
    pick(6);
    check("post_load_pick", 64'(face_up), 64'h0040);

    // Async reset mid-game
    #2;
    reset = 1'b0;
    #1;
    check("arst_face",  64'(face_up),   64'h0);
    check("arst_vals",  64'(tile_vals), 64'h0);
    check("arst_ready", 64'(sel_ready), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Saturation
    do_load();
    for (int k = 0; k < 255; k++) begin
      pick(0);
      pick(1);
      tick();
      wait_ready("sat_wait");
    end
    check("sat_moves_255", 64'(moves), 64'd255);
    pick(0);
    pick(1);
    tick();
    check("sat_miss",  64'(miss_pulse), 64'd1);
    check("sat_moves", 64'(moves),      64'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
